// File: rtl/layer_output_serializer_if.sv
// layer_output_serializer_if
//   Bundles the upstream layer result bus and the serialized stream that
//   feeds the next layer.
//   o_valid    : per-neuron result-valid pulses (bit i qualifies x_in slice i)
//   x_in       : all neuron results, neuron i at [i*dataWidth +: dataWidth]
//   x_out      : streamed word, one per clock
//   x_valid    : qualifies x_out
//   frame_last : high with the last word of a frame
//   busy       : shift bank holds an unfinished frame
//   overrun    : sticky collect-overrun error flag
//   slave  = serializer side, master = upstream layer / next layer side.
interface layer_output_serializer_if #(
    parameter int NN        = 30,
    parameter int dataWidth = 16
);
    logic [NN-1:0]           o_valid;
    logic [NN*dataWidth-1:0] x_in;
    logic [dataWidth-1:0]    x_out;
    logic                    x_valid;
    logic                    frame_last;
    logic                    busy;
    logic                    overrun;

    modport master (
        output o_valid, x_in,
        input  x_out, x_valid, frame_last, busy, overrun
    );

    modport slave (
        input  o_valid, x_in,
        output x_out, x_valid, frame_last, busy, overrun
    );
endinterface

// File: rtl/layer_output_serializer.sv
// layer_output_serializer
//   Collects the NN parallel results of an MLP layer into a collect bank and,
//   once every neuron has reported, hands the frame to a shift bank that
//   streams it out one word per clock (neuron 0 first). The two banks let the
//   next frame be collected while the current one is still streaming.
//   clk : clock, rising edge
//   rst : synchronous reset, active low
//   io  : layer_output_serializer_if.slave (o_valid/x_in in,
//         x_out/x_valid/frame_last/busy/overrun out, all outputs registered)
module layer_output_serializer #(
    parameter int NN        = 30,
    parameter int dataWidth = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    layer_output_serializer_if.slave   io
);
    localparam int IW = (NN > 1) ? $clog2(NN) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NN - 1);

    typedef enum logic {IDLE, STREAM} state_e;

    state_e                             state_q, state_d;
    logic [NN-1:0]                      mask_q, mask_d;
    logic [NN-1:0][dataWidth-1:0]       coll_q, coll_d;
    logic [NN-1:0][dataWidth-1:0]       shift_q, shift_d;
    logic [IW-1:0]                      idx_q, idx_d;
    logic [dataWidth-1:0]               x_out_q, x_out_d;
    logic                               x_valid_q, x_valid_d;
    logic                               frame_last_q, frame_last_d;
    logic                               overrun_q, overrun_d;
    logic                               xfer;
    logic                               ovr_hit;

    always_comb begin
        // A full collect bank moves over when the shifter is idle or is
        // presenting its last word, so consecutive frames stream gap-free.
        xfer = (&mask_q) && ((state_q == IDLE) || (idx_q == LAST_IDX));

        // Collect bank. A transfer frees every slot this edge, so a pulse
        // landing on the transfer edge is captured rather than flagged.
        coll_d  = coll_q;
        mask_d  = xfer ? '0 : mask_q;
        ovr_hit = 1'b0;
        for (int i = 0; i < NN; i++) begin
            if (io.o_valid[i]) begin
                if (xfer || !mask_q[i]) begin
                    coll_d[i] = io.x_in[i*dataWidth +: dataWidth];
                    mask_d[i] = 1'b1;
                end else begin
                    ovr_hit = 1'b1;
                end
            end
        end
        overrun_d = overrun_q | ovr_hit;

        // Shift bank
        state_d      = state_q;
        shift_d      = shift_q;
        idx_d        = idx_q;
        x_out_d      = x_out_q;
        x_valid_d    = x_valid_q;
        frame_last_d = 1'b0;
        if (xfer) begin
            state_d   = STREAM;
            shift_d   = coll_q;
            idx_d     = '0;
            x_out_d   = coll_q[0];
            x_valid_d = 1'b1;
        end else if (state_q == STREAM) begin
            if (idx_q == LAST_IDX) begin
                state_d   = IDLE;
                idx_d     = '0;
                x_out_d   = '0;
                x_valid_d = 1'b0;
            end else begin
                idx_d        = idx_q + IW'(1);
                x_out_d      = shift_q[idx_d];
                x_valid_d    = 1'b1;
                frame_last_d = (idx_d == LAST_IDX);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            mask_q       <= '0;
            idx_q        <= '0;
            x_out_q      <= '0;
            x_valid_q    <= 1'b0;
            frame_last_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            idx_q        <= idx_d;
            x_out_q      <= x_out_d;
            x_valid_q    <= x_valid_d;
            frame_last_q <= frame_last_d;
            overrun_q    <= overrun_d;
        end
    end

    // Data banks are qualified by mask/state, so they carry no reset.
    always_ff @(posedge clk) begin
        coll_q  <= coll_d;
        shift_q <= shift_d;
    end

    assign io.x_out      = x_out_q;
    assign io.x_valid    = x_valid_q;
    assign io.frame_last = frame_last_q;
    assign io.busy       = (state_q == STREAM);
    assign io.overrun    = overrun_q;
endmodule

// File: tb/tb_layer_output_serializer.sv
module tb_layer_output_serializer;
    localparam int NN = 4;
    localparam int DW = 16;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    layer_output_serializer_if #(.NN(NN), .dataWidth(DW)) io ();

    layer_output_serializer #(.NN(NN), .dataWidth(DW)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // slice i = {tag, 8'h00, i}: identifies which pulse delivered each word
    function automatic logic [NN*DW-1:0] mk(input logic [3:0] tag);
        logic [NN*DW-1:0] x;
        x = '0;
        for (int i = 0; i < NN; i++) x[i*DW +: DW] = {tag, 12'(i)};
        return x;
    endfunction

    // present o_valid/x_in for exactly one rising edge; returns at the
    // following falling edge with the inputs already cleared
    task automatic drive(input logic [NN-1:0] v, input logic [NN*DW-1:0] x);
        io.o_valid = v;
        io.x_in    = x;
        @(negedge clk);
        io.o_valid = '0;
    endtask

    task automatic test_reset;
        io.o_valid = '0;
        io.x_in    = '0;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++; if (io.x_valid !== 1'b0) begin bad++; $display("FAIL reset_x_valid got=%b want=0", io.x_valid); end
        total++; if (io.x_out !== 16'h0) begin bad++; $display("FAIL reset_x_out got=%h want=0000", io.x_out); end
        total++; if (io.frame_last !== 1'b0) begin bad++; $display("FAIL reset_frame_last got=%b want=0", io.frame_last); end
        total++; if (io.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", io.busy); end
        total++; if (io.overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", io.overrun); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single;
        logic [DW-1:0] exp [NN] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
        logic [DW+2:0] got, want;
        drive(4'b1111, {16'h0044, 16'h0033, 16'h0022, 16'h0011});
        total++; if (io.x_valid !== 1'b0) begin bad++; $display("FAIL single_latency x_valid got=%b want=0", io.x_valid); end
        for (int k = 0; k < NN; k++) begin
            @(negedge clk);
            got  = {io.x_valid, io.frame_last, io.busy, io.x_out};
            want = {1'b1, (k == NN-1), 1'b1, exp[k]};
            total++; if (got !== want) begin bad++; $display("FAIL single_word%0d {vld,last,busy,data} got=%h want=%h", k, got, want); end
        end
        @(negedge clk);
        total++; if ({io.x_valid, io.busy, io.frame_last} !== 3'b000) begin bad++; $display("FAIL single_end {vld,busy,last} got=%b want=000", {io.x_valid, io.busy, io.frame_last}); end
    endtask

    task automatic test_staggered;
        logic [DW-1:0] exp [NN] = '{16'h2000, 16'h3001, 16'h1002, 16'h3003};
        logic [DW+2:0] got, want;
        drive(4'b0100, mk(4'h1));
        total++; if (io.x_valid !== 1'b0) begin bad++; $display("FAIL stag_early1 x_valid got=%b want=0", io.x_valid); end
        drive(4'b0001, mk(4'h2));
        total++; if (io.x_valid !== 1'b0) begin bad++; $display("FAIL stag_early2 x_valid got=%b want=0", io.x_valid); end
        drive(4'b1010, mk(4'h3));
        total++; if (io.x_valid !== 1'b0) begin bad++; $display("FAIL stag_early3 x_valid got=%b want=0", io.x_valid); end
        for (int k = 0; k < NN; k++) begin
            @(negedge clk);
            got  = {io.x_valid, io.frame_last, io.busy, io.x_out};
            want = {1'b1, (k == NN-1), 1'b1, exp[k]};
            total++; if (got !== want) begin bad++; $display("FAIL stag_word%0d {vld,last,busy,data} got=%h want=%h", k, got, want); end
        end
        @(negedge clk);
        total++; if (io.x_valid !== 1'b0) begin bad++; $display("FAIL stag_end x_valid got=%b want=0", io.x_valid); end
    endtask

    task automatic test_back_to_back;
        logic [DW-1:0] exp [2*NN] = '{16'h5000, 16'h5001, 16'h5002, 16'h5003,
                                      16'h6000, 16'h6001, 16'h6002, 16'h6003};
        logic [DW+2:0] got, want;
        drive(4'b1111, mk(4'h5));
        for (int k = 0; k < 2*NN; k++) begin
            @(negedge clk);
            got  = {io.x_valid, io.frame_last, io.busy, io.x_out};
            want = {1'b1, (k == NN-1 || k == 2*NN-1), 1'b1, exp[k]};
            total++; if (got !== want) begin bad++; $display("FAIL b2b_cyc%0d {vld,last,busy,data} got=%h want=%h", k, got, want); end
            io.o_valid = (k == 1) ? 4'b1111 : 4'b0000;
            io.x_in    = mk(4'h6);
        end
        @(negedge clk);
        total++; if (io.x_valid !== 1'b0) begin bad++; $display("FAIL b2b_end x_valid got=%b want=0", io.x_valid); end
        total++; if (io.overrun !== 1'b0) begin bad++; $display("FAIL b2b_overrun got=%b want=0", io.overrun); end
    endtask

    task automatic test_same_edge;
        logic [DW-1:0] exp [2*NN] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044,
                                      16'h7000, 16'h8001, 16'h8002, 16'h8003};
        logic [DW+2:0] got, want;
        drive(4'b1111, {16'h0044, 16'h0033, 16'h0022, 16'h0011});
        // this pulse is sampled on the transfer edge
        drive(4'b0001, mk(4'h7));
        for (int k = 0; k < 2*NN; k++) begin
            got  = {io.x_valid, io.frame_last, io.busy, io.x_out};
            want = {1'b1, (k == NN-1 || k == 2*NN-1), 1'b1, exp[k]};
            total++; if (got !== want) begin bad++; $display("FAIL same_cyc%0d {vld,last,busy,data} got=%h want=%h", k, got, want); end
            io.o_valid = (k == 0) ? 4'b1110 : 4'b0000;
            io.x_in    = mk(4'h8);
            @(negedge clk);
        end
        total++; if (io.x_valid !== 1'b0) begin bad++; $display("FAIL same_end x_valid got=%b want=0", io.x_valid); end
        total++; if (io.overrun !== 1'b0) begin bad++; $display("FAIL same_overrun got=%b want=0", io.overrun); end
    endtask

    task automatic test_overrun_stream;
        logic [DW-1:0] exp [2*NN] = '{16'h9000, 16'h9001, 16'h9002, 16'h9003,
                                      16'hC000, 16'hC001, 16'hC002, 16'hC003};
        logic [NN*DW-1:0] beef;
        logic [DW+2:0] got, want;
        beef = '0;
        beef[1*DW +: DW] = 16'hBEEF;
        drive(4'b1111, mk(4'h9));
        io.o_valid = 4'b1111;
        io.x_in    = mk(4'hC);
        for (int k = 0; k < 2*NN; k++) begin
            @(negedge clk);
            got  = {io.x_valid, io.frame_last, io.busy, io.x_out};
            want = {1'b1, (k == NN-1 || k == 2*NN-1), 1'b1, exp[k]};
            total++; if (got !== want) begin bad++; $display("FAIL ovs_cyc%0d {vld,last,busy,data} got=%h want=%h", k, got, want); end
            if (k == 1) begin
                total++; if (io.overrun !== 1'b0) begin bad++; $display("FAIL ovs_pre overrun got=%b want=0", io.overrun); end
            end
            if (k >= 2) begin
                total++; if (io.overrun !== 1'b1) begin bad++; $display("FAIL ovs_flag%0d overrun got=%b want=1", k, io.overrun); end
            end
            io.o_valid = (k == 1) ? 4'b0010 : 4'b0000;
            io.x_in    = beef;
        end
        @(negedge clk);
        total++; if ({io.x_valid, io.overrun} !== 2'b01) begin bad++; $display("FAIL ovs_end {vld,overrun} got=%b want=01", {io.x_valid, io.overrun}); end
    endtask

    task automatic test_reset_mid_stream;
        logic [DW-1:0] exp [NN] = '{16'hB000, 16'hB001, 16'hA002, 16'hA003};
        logic [DW+2:0] got, want;
        drive(4'b1111, mk(4'hD));
        // partial next frame, must be forgotten by the reset
        drive(4'b0011, mk(4'hE));
        @(negedge clk);
        @(negedge clk);
        total++; if (io.x_out !== 16'hD002) begin bad++; $display("FAIL rms_word2 got=%h want=d002", io.x_out); end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        got  = {io.x_valid, io.frame_last, io.busy, io.x_out};
        total++; if (got !== '0) begin bad++; $display("FAIL rms_clear {vld,last,busy,data} got=%h want=0", got); end
        total++; if (io.overrun !== 1'b0) begin bad++; $display("FAIL rms_overrun got=%b want=0", io.overrun); end
        drive(4'b1100, mk(4'hA));
        total++; if (io.x_valid !== 1'b0) begin bad++; $display("FAIL rms_mask1 x_valid got=%b want=0", io.x_valid); end
        @(negedge clk);
        total++; if (io.x_valid !== 1'b0) begin bad++; $display("FAIL rms_mask2 x_valid got=%b want=0", io.x_valid); end
        drive(4'b0011, mk(4'hB));
        for (int k = 0; k < NN; k++) begin
            @(negedge clk);
            got  = {io.x_valid, io.frame_last, io.busy, io.x_out};
            want = {1'b1, (k == NN-1), 1'b1, exp[k]};
            total++; if (got !== want) begin bad++; $display("FAIL rms_word%0d {vld,last,busy,data} got=%h want=%h", k, got, want); end
        end
        @(negedge clk);
        total++; if (io.x_valid !== 1'b0) begin bad++; $display("FAIL rms_end x_valid got=%b want=0", io.x_valid); end
    endtask

    task automatic test_overrun_collect;
        logic [DW-1:0] exp [NN] = '{16'h4000, 16'h6001, 16'h6002, 16'h6003};
        logic [DW+2:0] got, want;
        drive(4'b0001, mk(4'h4));
        total++; if (io.overrun !== 1'b0) begin bad++; $display("FAIL ovc_first overrun got=%b want=0", io.overrun); end
        drive(4'b0001, mk(4'h5));
        total++; if (io.overrun !== 1'b1) begin bad++; $display("FAIL ovc_repeat overrun got=%b want=1", io.overrun); end
        drive(4'b1110, mk(4'h6));
        for (int k = 0; k < NN; k++) begin
            @(negedge clk);
            got  = {io.x_valid, io.frame_last, io.busy, io.x_out};
            want = {1'b1, (k == NN-1), 1'b1, exp[k]};
            total++; if (got !== want) begin bad++; $display("FAIL ovc_word%0d {vld,last,busy,data} got=%h want=%h", k, got, want); end
        end
        @(negedge clk);
        total++; if ({io.x_valid, io.overrun} !== 2'b01) begin bad++; $display("FAIL ovc_end {vld,overrun} got=%b want=01", {io.x_valid, io.overrun}); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        io.o_valid = '0;
        io.x_in    = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_staggered();
        test_back_to_back();
        test_same_edge();
        test_overrun_stream();
        test_reset_mid_stream();
        test_overrun_collect();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/layer_output_serializer.md
Name: layer_output_serializer

Overview:
- Sits directly downstream of a fully-parallel MLP layer.
- Collects the NN per-neuron results (x_out bus plus per-neuron o_valid pulses) into a collect bank.
- Once all NN results are present, transfers them to a shift bank and streams them one word per clock on x_out/x_valid.
- That stream drives the next layer's x_in/x_valid. Double-buffering lets a new layer result be collected while the previous one is still streaming.

Parameters:
- NN, 30, number of neurons in the upstream layer (words per frame); must be ≥2.
- dataWidth, 16, bits per neuron output / per streamed word.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous active-low reset.
- o_valid  input  NN  per-neuron output-valid pulses from the upstream layer; bit i qualifies slice i of x_in.
- x_in  input  NN*dataWidth  upstream neuron outputs; neuron i at [i*dataWidth +: dataWidth].
- x_out  output  dataWidth  streamed word, registered.
- x_valid  output  1  qualifies x_out, registered; high for exactly NN consecutive cycles per frame.
- frame_last  output  1  high with the last word (index NN-1) of each frame.
- busy  output  1  high while the shift bank holds an unfinished frame.
- overrun  output  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (rst==0 at an edge) clears:
  - all outputs to 0;
  - the collect mask;
  - the shift index;
  - the shift-bank-valid flag.
  - Data registers need not be cleared.
  - Reset mid-frame aborts the frame, with no further x_valid.
- Collect bank:
  - NN word registers plus an NN-bit mask.
  - At each edge, for every i with o_valid[i]==1 and the mask bit clear (or being cleared by a transfer this edge): store x_in slice i and set mask[i].
  - Any number of bits may pulse in the same cycle, in any order, across any number of cycles.
- Collect overrun:
  - Condition: o_valid[i]==1 while mask[i] is already set and no transfer occurs this edge.
  - Response: the new value is discarded, the old value is kept, and overrun is set to 1.
- Transfer condition, T = (mask all ones) AND (shift bank empty OR presenting index NN-1 this cycle).
- On a T edge:
  - copy the collect bank to the shift bank;
  - clear the mask, OR-ing in any o_valid bits sampled the same edge;
  - present word 0: x_out = word0, x_valid = 1, index = 0.
- Shift bank (the state machine is effectively IDLE / STREAM):
  - IDLE: x_valid = 0.
  - STREAM: each edge, index increments and x_out = word[index].
  - frame_last = 1 when index == NN-1.
  - After index NN-1: go to IDLE (x_valid = 0, busy = 0) unless T holds, in which case word 0 of the next frame follows with no gap.
- busy = shift bank valid (equals x_valid).
- Latency: last missing o_valid bit sampled at edge E, shifter idle → word 0 presented after edge E+1; word k after edge E+1+k; x_valid falls after edge E+NN+1.
- Full collect bank while shifting:
  - the mask stays full and T waits;
  - any o_valid pulse in this window is an overrun (discard, flag).
- No backpressure: the downstream layer always accepts.
- Word order on x_out is strictly neuron 0 → NN-1, independent of o_valid arrival order.

Test Plan:
- NN=4, dataWidth=16; all o_valid=4'b1111 in one cycle with x_in words 0x0011, 0x0022, 0x0033, 0x0044 → after 2 edges x_out streams 0011, 0022, 0033, 0044 on 4 consecutive cycles; frame_last only with 0044; then x_valid=0.
- Staggered arrival: o_valid bit 2, then bit 0, then bits 3|1 over 3 cycles → no output until the third pulse; stream order is still neuron 0..3; first word appears 2 edges after the third pulse.
- Back-to-back: a second full frame collected while the first streams (pulse during word 1) → 8 consecutive x_valid cycles, no gap; frame_last high on cycles 4 and 8.
- Overrun:
  - During streaming with the collect bank full, pulse o_valid[1]=1 with x_in[1]=0xBEEF → overrun=1 and stays 1; the next frame still carries the original word 1.
  - Also repeat bit 0 twice while collecting → overrun=1.
- Reset mid-stream: rst=0 while presenting word 2 → next cycle x_valid=0, x_out=0, busy=0, overrun=0, mask cleared; a subsequent full o_valid produces a normal 4-word frame.
- Same-edge transfer plus capture: o_valid[0] pulses on the transfer edge → the new value is held in the collect bank with mask bit 0 set, and no overrun.
